// File: rtl/rv32_mem_pkg.sv
// Shared constants and request type for the MA-stage data-memory responder.
package rv32_mem_pkg;
  localparam int XLEN  = 32;
  localparam int BYTES = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  typedef struct packed {
    logic            is_store;
    logic [2:0]      func3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_req_t;
endpackage

// File: rtl/load_store_align.sv
// RV32 lane steering: store byte enables/replication, load extension, fault detect.
module load_store_align
  import rv32_mem_pkg::*;
(
  input  logic [2:0]       func3,
  input  logic [1:0]       addr_lo,
  input  logic [XLEN-1:0]  write_data,
  input  logic [XLEN-1:0]  raw_word,
  output logic [BYTES-1:0] byte_en,
  output logic [XLEN-1:0]  wr_word,
  output logic [XLEN-1:0]  ld_word,
  output logic             fault
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign lane_byte = raw_word[{addr_lo, 3'b000} +: 8];
  assign lane_half = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];

  // fault covers misalignment and func3 codes that are illegal for loads;
  // the store-only restriction is applied by the caller
  always_comb begin
    byte_en = '0;
    wr_word = write_data;
    ld_word = '0;
    fault   = 1'b0;
    case (func3)
      F3_B, F3_BU: begin
        byte_en = 4'b0001 << addr_lo;
        wr_word = {4{write_data[7:0]}};
        ld_word = (func3 == F3_B) ? {{24{lane_byte[7]}}, lane_byte}
                                  : {24'd0, lane_byte};
      end
      F3_H, F3_HU: begin
        fault   = addr_lo[0];
        byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{write_data[15:0]}};
        ld_word = (func3 == F3_H) ? {{16{lane_half[15]}}, lane_half}
                                  : {16'd0, lane_half};
      end
      F3_W: begin
        fault   = |addr_lo;
        byte_en = 4'b1111;
        ld_word = raw_word;
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_memory_responder.sv
// MA-stage data memory: latches one load/store, stalls for LATENCY cycles, then commits.
//   state     | meaning
//   ST_IDLE   | waiting; busy follows mem_read|mem_write, request latched on accept
//   ST_ACCESS | counting down; commit on the cycle the counter reads zero
//   ST_DONE   | busy low, read_data/access_err valid; request not re-accepted
module data_memory_responder
  import rv32_mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] address,
  input  logic [XLEN-1:0] write_data,
  output logic [XLEN-1:0] read_data,
  output logic            busy,
  output logic            access_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  mem_req_t         req;
  logic [XLEN-1:0]  mem [DEPTH];

  logic [AW-1:0]    word_idx;
  logic [XLEN-1:0]  raw_word;
  logic [BYTES-1:0] byte_en;
  logic [XLEN-1:0]  wr_word;
  logic [XLEN-1:0]  ld_word;
  logic             fault;
  logic             err;
  logic             commit;
  logic             new_req;
  logic             unused_addr_hi;

  assign word_idx       = req.addr[AW+1:2];
  assign raw_word       = mem[word_idx];
  assign unused_addr_hi = ^req.addr[XLEN-1:AW+2];

  load_store_align u_align (
    .func3      (req.func3),
    .addr_lo    (req.addr[1:0]),
    .write_data (req.wdata),
    .raw_word   (raw_word),
    .byte_en    (byte_en),
    .wr_word    (wr_word),
    .ld_word    (ld_word),
    .fault      (fault)
  );

  // stores only allow B/H/W, so any func3 with bit 2 set is illegal for them
  assign err     = fault | (req.is_store & req.func3[2]);
  assign commit  = (state == ST_ACCESS) && (cnt == '0);
  assign new_req = mem_read | mem_write;

  always_comb begin
    busy = 1'b0;
    case (state)
      ST_IDLE:   busy = new_req;
      ST_ACCESS: busy = 1'b1;
      default:   busy = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      req        <= '0;
      read_data  <= '0;
      access_err <= 1'b0;
    end else begin
      access_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (new_req) begin
            req   <= '{is_store: mem_write, func3: func3,
                       addr: address, wdata: write_data};
            cnt   <= CW'(LATENCY - 1);
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            state      <= ST_DONE;
            access_err <= err;
            if (!req.is_store)
              read_data <= err ? '0 : ld_word;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // storage is intentionally not reset
  always_ff @(posedge CLK) begin
    if (commit && req.is_store && !err) begin
      for (int b = 0; b < BYTES; b++)
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized + directed bench for data_memory_responder against a byte-level memory model.
module tb_data_memory_responder;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int WIN   = 192;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        mem_read, mem_write;
  logic [2:0]  func3;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        busy, access_err;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_rd;

  data_memory_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .func3      (func3),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .busy       (busy),
    .access_err (access_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int access_size(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_fault(input bit is_store, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    bit legal;
    if (is_store) legal = (f3 <= 3'd2);
    else          legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
    if (!legal) return 1'b1;
    sz = access_size(f3);
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] f3, input int lane);
    int sz;
    longint unsigned v;
    sz = access_size(f3);
    v  = (longint'(word) >> (lane * 8)) & ((64'd1 << (sz * 8)) - 1);
    if (!f3[2] && sz < 4 && v >= (64'd1 << (sz * 8 - 1)))
      v = v - (64'd1 << (sz * 8));
    return v[31:0];
  endfunction

  task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input bit drop);
    bit          st, flt;
    int          idx, lane, sz, nbusy;
    logic [31:0] w;
    st   = wr;
    idx  = int'(a[11:2]);
    lane = int'(a[1:0]);
    flt  = model_fault(st, f3, a);
    if (!flt) begin
      if (st) begin
        sz = access_size(f3);
        w  = ref_mem[idx];
        for (int k = 0; k < sz; k++)
          w[8*(lane+k) +: 8] = wd[8*k +: 8];
        ref_mem[idx] = w;
      end else begin
        ref_rd = model_load(ref_mem[idx], f3, lane);
      end
    end else if (!st) begin
      ref_rd = 32'd0;
    end

    mem_read = rd; mem_write = wr; func3 = f3; address = a; write_data = wd;
    #1;
    nbusy = 0;
    while (busy && nbusy < 50) begin
      nbusy++;
      @(negedge CLK);
    end
    check("busy_cycles", nbusy, LAT + 1);
    check("read_data", read_data, ref_rd);
    check("access_err", {31'd0, access_err}, {31'd0, flt});
    if (drop) begin
      mem_read = 1'b0; mem_write = 1'b0;
      @(negedge CLK);
      check("err_cleared", {31'd0, access_err}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    int  nb;
    logic [2:0]  f3;
    logic [31:0] a;
    int  r;

    RESET = 1'b0; mem_read = 0; mem_write = 0; func3 = 0; address = 0; write_data = 0;
    ref_rd = 32'd0;
    foreach (ref_mem[i]) ref_mem[i] = 32'd0;
    repeat (3) @(negedge CLK);
    check("rst_read_data", read_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, access_err}, 32'd0);
    RESET = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < WIN; i++)
      do_access(1'b0, 1'b1, 3'b010, 32'(i * 4), 32'd0, 1'b1);

    do_access(0, 1, 3'b010, 32'h40, 32'hDEADBEEF, 1);
    do_access(1, 0, 3'b010, 32'h40, 32'h0, 1);
    check("lw_deadbeef", read_data, 32'hDEADBEEF);

    do_access(0, 1, 3'b000, 32'h101, 32'h00000080, 1);
    do_access(1, 0, 3'b000, 32'h101, 32'h0, 1);
    check("lb_sext", read_data, 32'hFFFFFF80);
    do_access(1, 0, 3'b100, 32'h101, 32'h0, 1);
    check("lbu_zext", read_data, 32'h00000080);
    do_access(1, 0, 3'b010, 32'h100, 32'h0, 1);
    check("lw_after_sb", read_data, 32'h00008000);

    do_access(0, 1, 3'b001, 32'h202, 32'h00001234, 1);
    do_access(1, 0, 3'b101, 32'h202, 32'h0, 1);
    check("lhu_1234", read_data, 32'h00001234);
    do_access(0, 1, 3'b001, 32'h203, 32'h0000BEEF, 1);
    do_access(1, 0, 3'b001, 32'h203, 32'h0, 1);
    check("lh_misaligned_zero", read_data, 32'd0);
    do_access(1, 0, 3'b010, 32'h200, 32'h0, 1);
    check("sh_misaligned_nowrite", read_data, 32'h12340000);

    // back-to-back held loads: second must start right after DONE
    do_access(1, 0, 3'b010, 32'h40, 32'h0, 0);
    address = 32'h44;
    @(negedge CLK);
    check("b2b_accept", {31'd0, busy}, 32'd1);
    do_access(1, 0, 3'b010, 32'h44, 32'h0, 1);

    // reset mid-access abandons the store
    do_access(1, 0, 3'b010, 32'h40, 32'h0, 1);
    mem_write = 1'b1; func3 = 3'b010; address = 32'h80; write_data = 32'hAAAA5555;
    @(negedge CLK);
    mem_write = 1'b0;
    RESET = 1'b0;
    ref_rd = 32'd0;
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_read_data", read_data, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    do_access(1, 0, 3'b010, 32'h80, 32'h0, 1);
    check("rst_no_commit", read_data, 32'd0);

    // read+write together is a store
    do_access(1, 0, 3'b010, 32'h40, 32'h0, 1);
    do_access(1, 1, 3'b010, 32'h10, 32'h11223344, 1);
    check("both_keeps_rd", read_data, 32'hDEADBEEF);
    do_access(1, 0, 3'b010, 32'h10, 32'h0, 1);
    check("both_stored", read_data, 32'h11223344);

    // aliasing through ignored upper address bits
    do_access(1, 0, 3'b010, 32'h0000_1040, 32'h0, 1);
    check("alias_lw", read_data, 32'hDEADBEEF);

    for (int i = 0; i < 300; i++) begin
      r  = $urandom_range(0, 9);
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, WIN - 1) * 4) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_F000);
      if (r < 5)      do_access(1, 0, f3, a, $urandom, 1);
      else if (r < 9) do_access(0, 1, f3, a, $urandom, 1);
      else            do_access(1, 1, f3, a, $urandom, 1);
    end

    nb = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Data-memory responder for the Memory Access stage of the RV32IM pipeline.
- Accepts the MA stage's load/store requests (mem_read, mem_write, func3, address, store data) and returns load data after a configurable latency.
- Asserts busy so the pipeline stalls while a request is outstanding.
- Implements RV32 byte/half/word lanes, load sign/zero extension, misalignment and illegal-func3 detection, and a word-organised storage array.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, ≥ 4.
- LATENCY, 2, ACCESS-state cycles before commit; ≥ 1.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- mem_read  input  1  load request from MA stage.
- mem_write  input  1  store request from MA stage.
- func3  input  3  RV32 load/store width code.
- address  input  32  byte address (ALU result).
- write_data  input  32  store data (rs2 value).
- read_data  output  32  load result, extended per func3.
- busy  output  1  stall request to pipeline registers.
- access_err  output  1  one-cycle pulse: misaligned access or illegal func3.

Behaviour:
- Reset (RESET=0, asynchronous):
  - state=IDLE, busy=0, read_data=0, access_err=0, counter=0, latched request cleared.
  - Array contents are not cleared.
  - Reset during ACCESS abandons the request; no write is committed.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - req = mem_read | mem_write.
  - busy = req, combinational.
  - If req: latch address, write_data, func3 and the operation type; mem_write has priority if both are set, and the access is then treated as a store. Load counter with LATENCY-1 and go to ACCESS.
- ACCESS:
  - busy=1. Counter decrements each cycle.
  - When counter==0, commit and go to DONE:
    - store: byte-enabled write to the array.
    - load: register the extended data into read_data.
- DONE:
  - busy=0; read_data is valid. Pipeline registers advance on this edge.
  - Next state is IDLE unconditionally; the request still presented during DONE is never re-accepted.
- Throughput and latency:
  - busy is high for LATENCY+1 cycles per access.
  - A new request presented on the cycle after DONE is accepted with no extra bubble.
- Address mapping:
  - word index = address[log2(DEPTH)+1:2]; upper bits are ignored (aliasing).
  - Byte lane = address[1:0].
- Loads:
  - LB 000: sign-extend byte. LBU 100: zero-extend byte.
  - LH 001: sign-extend half. LHU 101: zero-extend half.
  - LW 010: full word.
- Stores:
  - SB 000: one byte enable. SH 001: two enables. SW 010: all four enables.
  - Store data is taken from write_data low bits, replicated to the selected lane.
- Errors:
  - Misaligned: half access with address[0]=1, or word access with address[1:0]≠0.
  - Illegal func3: 011, 110, 111; for stores, any func3 > 010.
  - On error: no write occurs, read_data is set to 0, and access_err=1 during DONE only.
- read_data holds its value until the next load completes or reset; stores do not change it.
- access_err is 0 in every cycle except DONE of an erroneous access.

Decomposition:
- Shared package rv32_mem_pkg:
  - func3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state encoding for IDLE, ACCESS, DONE.
  - Width localparams: XLEN=32, BYTES=4.
- One combinational sub-module, load_store_align:
  - Inputs: func3, address[1:0], write_data, raw word.
  - Outputs: byte_en[3:0], aligned write word, extended load word, misaligned/illegal flag.
- The responder holds the FSM, counter, request latches and array.

Test Plan:
- SW 0xDEADBEEF @0x40, then LW @0x40 (LATENCY=2) -> busy high exactly 3 cycles per access; read_data=0xDEADBEEF in DONE; access_err=0.
- SB 0x80 @0x101 over word 0 -> LB @0x101 gives 0xFFFFFF80; LBU gives 0x00000080; LW @0x100 gives 0x00008000 (bytes 0, 2, 3 unchanged from 0).
- SH @0x202 (0x1234), then SH @0x203 -> first commits (LHU @0x202 = 0x00001234); second pulses access_err in DONE, memory unchanged, read_data=0 for LH @0x203.
- Back-to-back LW @0x40, LW @0x44 held continuously -> second accepted in the cycle after DONE; exactly 2×(LATENCY+1) busy cycles; no duplicate accept.
- SW 0xAAAA5555 @0x80, RESET asserted mid-ACCESS (counter≠0) -> busy/read_data drop to 0 immediately; later LW @0x80 returns prior content (0).
- mem_read=mem_write=1, func3=010, @0x10, data 0x11223344 -> treated as store; read_data unchanged; subsequent LW @0x10 = 0x11223344.
